dunc16_sequencer: RTL and testbench

//  Control sequencer for the dunc16 16-bit accumulator CPU; sits directly upstream of the datapath.

---
 rtl/dunc16_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_dunc16_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dunc16_sequencer.sv
// Control sequencer for the dunc16 accumulator CPU: T0..T3 phase ring, FETCH/EXECUTE/HALT state
// and per-phase datapath strobes. Define DUNC16_STEP_EN to add the STEP single-step input.
module dunc16_sequencer (
    input  logic       CLK,
    input  logic       RESET,
`ifdef DUNC16_STEP_EN
    input  logic       STEP,
`endif
    input  logic [3:0] IR_OP,
    output logic       T0,
    output logic       T1,
    output logic       T2,
    output logic       T3,
    output logic       FETCH,
    output logic       EXECUTE,
    output logic       HALTED,
    output logic       MA_LD_PC,
    output logic       MA_LD_IR,
    output logic       MEM_RD,
    output logic       IR_LD,
    output logic       PC_INC,
    output logic       PC_LD,
    output logic       AC_LD,
    output logic       AC_ADD,
    output logic       AC_AND,
    output logic       I_STA,
    output logic       SETWRITE,
    output logic       CLRWRITE,
    output logic       WRITE
);

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_HLT = 4'hF;

`ifdef DUNC16_STEP_EN
    localparam bit StepEn = 1'b1;
`else
    localparam bit StepEn = 1'b0;
`endif

    typedef enum logic [3:0] {
        PhT0 = 4'b0001,
        PhT1 = 4'b0010,
        PhT2 = 4'b0100,
        PhT3 = 4'b1000
    } phase_e;

    // Encoded so that bit0 = FETCH, bit1 = EXECUTE, bit2 = HALTED; halt keeps FETCH high.
    typedef enum logic [2:0] {
        StFetch = 3'b001,
        StExec  = 3'b010,
        StHalt  = 3'b101
    } major_e;

    phase_e ring_q, ring_d;
    major_e major_q, major_d;
    logic   hold_q, hold_d;
    logic   write_q, write_d;
    logic   step_rise;
    logic   active;

`ifdef DUNC16_STEP_EN
    logic [1:0] step_sync_q;
    logic       step_prev_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            step_sync_q <= 2'b00;
            step_prev_q <= 1'b0;
        end else begin
            step_sync_q <= {step_sync_q[0], STEP};
            step_prev_q <= step_sync_q[1];
        end
    end

    assign step_rise = step_sync_q[1] & ~step_prev_q;
`else
    assign step_rise = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ring_q  <= PhT0;
            major_q <= StFetch;
            hold_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            ring_q  <= ring_d;
            major_q <= major_d;
            hold_q  <= hold_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        ring_d  = ring_q;
        major_d = major_q;
        hold_d  = hold_q;
        if (major_q == StHalt) begin
            ring_d = PhT0;
        end else if (hold_q) begin
            if (step_rise) hold_d = 1'b0;
        end else begin
            case (ring_q)
                PhT0:    ring_d = PhT1;
                PhT1:    ring_d = PhT2;
                PhT2:    ring_d = PhT3;
                default: ring_d = PhT0;
            endcase
            if (ring_q == PhT3) begin
                if (major_q == StFetch) begin
                    case (IR_OP)
                        OP_JMP:  hold_d = StepEn;
                        OP_HLT:  major_d = StHalt;
                        default: major_d = StExec;
                    endcase
                end else begin
                    major_d = StFetch;
                    hold_d  = StepEn;
                end
            end
        end
    end

    // Strobes are forced low while RESET is asserted even though state already reads as fetch T0.
    assign active = ~RESET & (major_q != StHalt) & ~hold_q;

    always_comb begin
        MA_LD_PC = 1'b0;
        MA_LD_IR = 1'b0;
        MEM_RD   = 1'b0;
        IR_LD    = 1'b0;
        PC_INC   = 1'b0;
        PC_LD    = 1'b0;
        AC_LD    = 1'b0;
        AC_ADD   = 1'b0;
        AC_AND   = 1'b0;
        SETWRITE = 1'b0;
        CLRWRITE = 1'b0;
        if (active) begin
            if (major_q == StFetch) begin
                case (ring_q)
                    PhT0: MA_LD_PC = 1'b1;
                    PhT1: MEM_RD = 1'b1;
                    PhT2: begin
                        IR_LD  = 1'b1;
                        PC_INC = 1'b1;
                    end
                    default: PC_LD = (IR_OP == OP_JMP);
                endcase
            end else begin
                case (ring_q)
                    PhT0: MA_LD_IR = 1'b1;
                    PhT1: begin
                        SETWRITE = (IR_OP == OP_STA);
                        MEM_RD   = (IR_OP == OP_LDA) || (IR_OP == OP_ADD) || (IR_OP == OP_AND);
                    end
                    PhT2: begin
                        CLRWRITE = (IR_OP == OP_STA);
                        AC_LD    = (IR_OP == OP_LDA);
                        AC_ADD   = (IR_OP == OP_ADD);
                        AC_AND   = (IR_OP == OP_AND);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        write_d = write_q;
        if (SETWRITE) write_d = 1'b1;
        else if (CLRWRITE) write_d = 1'b0;
    end

    assign I_STA   = (IR_OP == OP_STA);
    assign T0      = ring_q[0];
    assign T1      = ring_q[1];
    assign T2      = ring_q[2];
    assign T3      = ring_q[3];
    assign FETCH   = major_q[0];
    assign EXECUTE = major_q[1];
    assign HALTED  = major_q[2];
    assign WRITE   = write_q;

endmodule

// File: tb/tb_dunc16_sequencer.sv
// Directed self-checking bench for dunc16_sequencer; sampled 1 ns after the falling clock edge.
module tb_dunc16_sequencer;

    logic       CLK;
    logic       RESET;
    logic [3:0] IR_OP;
`ifdef DUNC16_STEP_EN
    logic       STEP;
    localparam bit StepMode = 1'b1;
`else
    localparam bit StepMode = 1'b0;
`endif
    logic T0, T1, T2, T3, FETCH, EXECUTE, HALTED;
    logic MA_LD_PC, MA_LD_IR, MEM_RD, IR_LD, PC_INC, PC_LD;
    logic AC_LD, AC_ADD, AC_AND, I_STA, SETWRITE, CLRWRITE, WRITE;

    int n_vec  = 0;
    int n_miss = 0;

    // Strobe vector bit positions
    localparam logic [10:0] S_MAPC = 11'h400;
    localparam logic [10:0] S_MAIR = 11'h200;
    localparam logic [10:0] S_RD   = 11'h100;
    localparam logic [10:0] S_IRLD = 11'h080;
    localparam logic [10:0] S_PCIN = 11'h040;
    localparam logic [10:0] S_PCLD = 11'h020;
    localparam logic [10:0] S_ACLD = 11'h010;
    localparam logic [10:0] S_ADD  = 11'h008;
    localparam logic [10:0] S_AND  = 11'h004;
    localparam logic [10:0] S_SETW = 11'h002;
    localparam logic [10:0] S_CLRW = 11'h001;

    dunc16_sequencer dut (
        .CLK      (CLK),
        .RESET    (RESET),
`ifdef DUNC16_STEP_EN
        .STEP     (STEP),
`endif
        .IR_OP    (IR_OP),
        .T0       (T0),
        .T1       (T1),
        .T2       (T2),
        .T3       (T3),
        .FETCH    (FETCH),
        .EXECUTE  (EXECUTE),
        .HALTED   (HALTED),
        .MA_LD_PC (MA_LD_PC),
        .MA_LD_IR (MA_LD_IR),
        .MEM_RD   (MEM_RD),
        .IR_LD    (IR_LD),
        .PC_INC   (PC_INC),
        .PC_LD    (PC_LD),
        .AC_LD    (AC_LD),
        .AC_ADD   (AC_ADD),
        .AC_AND   (AC_AND),
        .I_STA    (I_STA),
        .SETWRITE (SETWRITE),
        .CLRWRITE (CLRWRITE),
        .WRITE    (WRITE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [10:0] strobes();
        return {MA_LD_PC, MA_LD_IR, MEM_RD, IR_LD, PC_INC, PC_LD, AC_LD, AC_ADD, AC_AND,
                SETWRITE, CLRWRITE};
    endfunction

    task automatic next_cycle();
        @(negedge CLK);
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] op);
        RESET = 1'b1;
        IR_OP = op;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_ring;
        RESET = 1'b1;
        IR_OP = 4'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        n_vec++;
        if ({T3, T2, T1, T0, FETCH, EXECUTE, HALTED, WRITE} !== 8'b0001_1000) begin
            n_miss++;
            $display("FAIL reset_state: got %b expected %b",
                     {T3, T2, T1, T0, FETCH, EXECUTE, HALTED, WRITE}, 8'b0001_1000);
        end
        n_vec++;
        if (strobes() !== 11'h000) begin
            n_miss++;
            $display("FAIL reset_strobes: got %b expected %b", strobes(), 11'h000);
        end
        RESET = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_ring = 4'b0001 << (i % 4);
            n_vec++;
            if ({T3, T2, T1, T0} !== exp_ring) begin
                n_miss++;
                $display("FAIL ring cyc %0d: got %b expected %b", i, {T3, T2, T1, T0}, exp_ring);
            end
            next_cycle();
        end
    endtask

    // LDA/ADD/AND and an undefined opcode as a NOP: 8-cycle instruction each
    task automatic test_exec_ops();
        logic [3:0]  ops [4];
        logic [10:0] exp [8];
        logic [10:0] rd_s, acc_s;
        ops[0] = 4'h0; ops[1] = 4'h2; ops[2] = 4'h3; ops[3] = 4'h7;
        for (int k = 0; k < 4; k++) begin
            rd_s  = (k == 3) ? 11'h000 : S_RD;
            acc_s = (k == 0) ? S_ACLD : (k == 1) ? S_ADD : (k == 2) ? S_AND : 11'h000;
            exp[0] = S_MAPC; exp[1] = S_RD; exp[2] = S_IRLD | S_PCIN; exp[3] = 11'h000;
            exp[4] = S_MAIR; exp[5] = rd_s; exp[6] = acc_s; exp[7] = 11'h000;
            apply_reset(ops[k]);
            for (int c = 0; c < 8; c++) begin
                n_vec++;
                if (strobes() !== exp[c] || FETCH !== (c < 4) || EXECUTE !== (c >= 4)) begin
                    n_miss++;
                    $display("FAIL exec op %h cyc %0d: got strobes %b F%b E%b expected %b F%b E%b",
                             ops[k], c, strobes(), FETCH, EXECUTE, exp[c], c < 4, c >= 4);
                end
                next_cycle();
            end
            n_vec++;
            if ({FETCH, EXECUTE, T0, I_STA} !== 4'b1010) begin
                n_miss++;
                $display("FAIL refetch op %h: got %b expected %b", ops[k],
                         {FETCH, EXECUTE, T0, I_STA}, 4'b1010);
            end
        end
    endtask

    task automatic test_sta();
        logic [10:0] exp [8];
        exp[0] = S_MAPC; exp[1] = S_RD; exp[2] = S_IRLD | S_PCIN; exp[3] = 11'h000;
        exp[4] = S_MAIR; exp[5] = S_SETW; exp[6] = S_CLRW; exp[7] = 11'h000;
        apply_reset(4'h1);
        for (int c = 0; c < 9; c++) begin
            n_vec++;
            if ((c < 8 && strobes() !== exp[c]) || WRITE !== (c == 6) || I_STA !== 1'b1) begin
                n_miss++;
                $display("FAIL sta cyc %0d: got strobes %b W%b I%b expected %b W%b I1",
                         c, strobes(), WRITE, I_STA, (c < 8) ? exp[c] : 11'h400, c == 6);
            end
            next_cycle();
        end
    endtask

    task automatic test_jmp();
        logic [10:0] exp [6];
        exp[0] = S_MAPC; exp[1] = S_RD; exp[2] = S_IRLD | S_PCIN; exp[3] = S_PCLD;
        exp[4] = StepMode ? 11'h000 : S_MAPC;
        exp[5] = StepMode ? 11'h000 : S_RD;
        apply_reset(4'h4);
        for (int c = 0; c < 6; c++) begin
            n_vec++;
            if (strobes() !== exp[c] || FETCH !== 1'b1 || EXECUTE !== 1'b0) begin
                n_miss++;
                $display("FAIL jmp cyc %0d: got strobes %b F%b E%b expected %b F1 E0",
                         c, strobes(), FETCH, EXECUTE, exp[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_halt();
        apply_reset(4'hF);
        repeat (3) next_cycle();
        n_vec++;
        if (HALTED !== 1'b0 || T3 !== 1'b1 || strobes() !== 11'h000) begin
            n_miss++;
            $display("FAIL halt_t3: got H%b T3%b strobes %b expected H0 T31 strobes 0",
                     HALTED, T3, strobes());
        end
        next_cycle();
        IR_OP = 4'h0;
        for (int c = 0; c < 20; c++) begin
            n_vec++;
            if ({HALTED, FETCH, EXECUTE, T3, T2, T1, T0} !== 7'b110_0001 ||
                strobes() !== 11'h000 || WRITE !== 1'b0) begin
                n_miss++;
                $display("FAIL halted cyc %0d: got %b strobes %b expected %b strobes 0",
                         c, {HALTED, FETCH, EXECUTE, T3, T2, T1, T0}, strobes(), 7'b110_0001);
            end
            next_cycle();
        end
        apply_reset(4'h0);
        n_vec++;
        if (HALTED !== 1'b0 || MA_LD_PC !== 1'b1) begin
            n_miss++;
            $display("FAIL halt_clear: got H%b MAPC%b expected H0 MAPC1", HALTED, MA_LD_PC);
        end
    endtask

    task automatic test_reset_mid_sta();
        apply_reset(4'h1);
        repeat (6) next_cycle();
        n_vec++;
        if (WRITE !== 1'b1 || T2 !== 1'b1) begin
            n_miss++;
            $display("FAIL pre_reset_write: got W%b T2%b expected W1 T21", WRITE, T2);
        end
        RESET = 1'b1;
        #1;
        n_vec++;
        if ({WRITE, T0, T2, FETCH, EXECUTE} !== 5'b01010) begin
            n_miss++;
            $display("FAIL async_reset: got %b expected %b",
                     {WRITE, T0, T2, FETCH, EXECUTE}, 5'b01010);
        end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
    endtask

`ifdef DUNC16_STEP_EN
    task automatic test_step();
        STEP = 1'b0;
        apply_reset(4'h0);
        repeat (8) next_cycle();
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (strobes() !== 11'h000 || T0 !== 1'b1 || FETCH !== 1'b1) begin
                n_miss++;
                $display("FAIL step_hold cyc %0d: got strobes %b T0%b expected 0 T01",
                         c, strobes(), T0);
            end
            next_cycle();
        end
        STEP = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            n_vec++;
            if (MA_LD_PC !== (c == 2)) begin
                n_miss++;
                $display("FAIL step_latency cyc %0d: got %b expected %b", c, MA_LD_PC, c == 2);
            end
        end
        repeat (8) next_cycle();
        for (int c = 0; c < 6; c++) begin
            n_vec++;
            if (strobes() !== 11'h000 || T0 !== 1'b1) begin
                n_miss++;
                $display("FAIL step_one_instr cyc %0d: got strobes %b expected 0", c, strobes());
            end
            next_cycle();
        end
        STEP = 1'b0;
    endtask
`endif

    initial begin
        RESET = 1'b1;
        IR_OP = 4'h0;
`ifdef DUNC16_STEP_EN
        STEP  = 1'b0;
`endif
        test_reset();
        test_exec_ops();
        test_sta();
        test_jmp();
        test_halt();
        test_reset_mid_sta();
`ifdef DUNC16_STEP_EN
        test_step();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
